arb_mux_nto1: RTL and testbench
===============================

Name: arb_mux_nto1

Overview:
- Parametrised successor to the datapath 2:1 select: an N-input, WIDTH-bit registered multiplexer with per-input valid/ready handshakes.
- Built-in arbitration, either round-robin or fixed priority, replaces the external select line.
- Feeds one shared downstream consumer, e.g. a shared writeback or memory-request port, through a single output register with 1-cycle latency.
- Full throughput: one transfer per cycle when downstream is ready.

Parameters:
- WIDTH, 64, data width of each input and of the output.
- N, 4, number of input channels (N >= 1).
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- SEL_W, derived localparam = max(1, clog2(N)), width of the channel index.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  N  bit i set: channel i presents data.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  bit i set: channel i is granted this cycle.
- out_valid  output  1  output register holds a valid word.
- out_data  output  WIDTH  registered data of the granted channel.
- out_sel  output  SEL_W  index of the channel that out_data came from.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset, synchronous and active-high, sampled at the clk edge:
  - out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
  - in_ready is forced to all-zero while reset is high.
  - Reset mid-transfer discards the held word, with no handshake completing.
- Load enable: load = ~out_valid | out_ready. The register is empty, or is draining this cycle.
- Grant (combinational, one-hot or zero):
  - Choose the first i with in_valid[i]=1, searching i = ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
  - in_ready[i] = grant[i] & load. No in_valid means no grant.
  - in_ready depends on in_valid. Upstream must not make in_valid depend on in_ready.
- Input transfer: an input transfer occurs on channel i when in_valid[i] & in_ready[i].
  - At that clk edge: out_data <= in_data[i], out_sel <= i, out_valid <= 1.
  - Latency from input handshake to out_valid is 1 cycle.
- Drain: an output transfer occurs on out_valid & out_ready.
  - If no input transfer happens in the same cycle, out_valid <= 0.
  - out_data and out_sel keep their last values when the register is empty.
- Simultaneous drain and load: the new word replaces the old one in the same edge and out_valid stays 1. This gives full throughput.
- Stall: while out_valid & ~out_ready, out_data and out_sel are held stable and in_ready=0 on all channels.
- Pointer update:
  - RR=1: on each input transfer from channel i, ptr <= (i+1) mod N, wrapping from N-1 to 0. Without a transfer, ptr holds.
  - RR=0: ptr is constantly 0.
- Fairness (RR=1): with all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,...
- N=1: out_sel is constantly 0, ptr is constantly 0, and the block degenerates to a 1-entry pipeline register.
- No combinational path from out_ready to out_data. out_ready reaches in_ready only through the load term.

Decomposition:
- Shared include legv8_defs.vh holds:
  - DATA_W=64;
  - a clog2 constant function;
  - the arbitration mode constants ARB_FIXED=0 and ARB_RR=1.
- One combinational sub-module, rr_grant_nto1 (parameters N, SEL_W):
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: one-hot grant[N], grant index idx[SEL_W], any_grant.
  - It is reused for fixed priority by tying ptr to 0.
- The top level holds the output register, the pointer register and the data select (indexed part-select by idx).

Test Plan:
- Reset check: hold reset=1 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_sel=0. Release reset -> the first grant goes to channel 0.
- Round-robin fairness: RR=1, N=4, in_valid=1111, ch i data=64'hA0+i, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, with out_data 0xA0..0xA3 repeating and out_valid=1 every cycle after the first.
- Fixed priority: RR=0, in_valid=0110 held -> channel 1 is granted every cycle and channel 2 is never granted. Then drop bit 1 -> channel 2 is granted on the next cycle.
- Backpressure: out_valid=1 holding ch2 data 64'hDEAD, out_ready=0 for 3 cycles with in_valid=1111 -> out_data stays 0xDEAD, in_ready=0000, ptr unchanged. Raise out_ready -> the same-cycle load grants channel 3.
- Sparse traffic and wrap: ptr=3, only in_valid[0]=1 -> grant to channel 0, then ptr=1. With no inputs valid and out_ready=1, out_valid falls to 0 one cycle after the drain.
- Reset mid-operation: assert reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and ptr=0. The held word is never reported as transferred.

Source files
------------

// File: rtl/arb_mux_nto1_pkg.sv
// arb_mux_nto1_pkg: shared widths, arbitration mode constants and index-width helpers
package arb_mux_nto1_pkg;
  localparam int DATA_W = 64;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int sel_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/arb_mux_nto1_grant.sv
// rr_grant_nto1: rotating-priority one-hot grant starting the search at ptr
module rr_grant_nto1 import arb_mux_nto1_pkg::*; #(
  parameter int N = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx,
  output logic             any_grant
);
  // search ptr..N-1 first, falling back to 0..ptr-1; reverse loops leave the lowest hit
  always_comb begin
    grant = '0;
    idx = '0;
    any_grant = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && i < int'(ptr)) begin
        grant = '0;
        grant[i] = 1'b1;
        idx = SEL_W'(i);
        any_grant = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && i >= int'(ptr)) begin
        grant = '0;
        grant[i] = 1'b1;
        idx = SEL_W'(i);
        any_grant = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arb_mux_nto1.sv
// arb_mux_nto1: N-input arbitrated multiplexer into a single registered valid/ready output
module arb_mux_nto1 import arb_mux_nto1_pkg::*; #(
  parameter int WIDTH = DATA_W,
  parameter int N = 4,
  parameter int RR = ARB_RR,
  localparam int SEL_W = sel_w(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] idx;
  logic             any_grant;
  logic             load;
  logic             xfer;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  rr_grant_nto1 #(.N(N), .SEL_W(SEL_W)) u_grant (
    .req       (in_valid),
    .ptr       (RR == ARB_RR ? ptr_q : '0),
    .grant     (grant),
    .idx       (idx),
    .any_grant (any_grant)
  );

  // load when empty or draining; a transfer captures the granted channel and advances the pointer
  always_comb begin
    load = ~out_valid_q | out_ready;
    xfer = any_grant & load & ~reset;
    in_ready = reset ? '0 : grant & {N{load}};
    out_valid_d = xfer | (out_valid_q & ~out_ready);
    out_data_d = xfer ? in_data[int'(idx)*WIDTH +: WIDTH] : out_data_q;
    out_sel_d = xfer ? idx : out_sel_q;
    ptr_d = (RR != ARB_RR) ? '0 : xfer ? SEL_W'((int'(idx) + 1) % N) : ptr_q;
  end

  // output register and priority pointer, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
      ptr_q <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
endmodule

// File: tb/tb_arb_mux_nto1.sv
// tb_arb_mux_nto1: directed checks of round-robin and fixed-priority arbitration
module tb_arb_mux_nto1;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_valid;
  logic [255:0] in_data;
  logic         out_ready;
  logic [3:0]   rr_in_ready, fp_in_ready;
  logic         rr_out_valid, fp_out_valid;
  logic [63:0]  rr_out_data, fp_out_data;
  logic [1:0]   rr_out_sel, fp_out_sel;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  arb_mux_nto1 #(.WIDTH(64), .N(4), .RR(1)) u_rr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
    .out_sel(rr_out_sel), .out_ready(out_ready)
  );

  arb_mux_nto1 #(.WIDTH(64), .N(4), .RR(0)) u_fp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
    .out_sel(fp_out_sel), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i*64 +: 64] = 64'hA0 + 64'(i);
    tick();
    tick();
    chk("rst_in_ready_rr", 64'(rr_in_ready), 64'h0);
    chk("rst_in_ready_fp", 64'(fp_in_ready), 64'h0);
    chk("rst_out_valid", 64'(rr_out_valid), 64'h0);
    chk("rst_out_data", rr_out_data, 64'h0);
    chk("rst_out_sel", 64'(rr_out_sel), 64'h0);
    reset = 1'b0;
    #1;
    chk("first_grant", 64'(rr_in_ready), 64'b0001);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_sel", 64'(rr_out_sel), 64'(k % 4));
      chk("rr_data", rr_out_data, 64'hA0 + 64'(k % 4));
      chk("rr_valid", 64'(rr_out_valid), 64'h1);
    end
    chk("rr_ptr_wrap", 64'(u_rr.ptr_q), 64'h0);
    in_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fp_in_ready", 64'(fp_in_ready), 64'b0010);
      tick();
      chk("fp_sel", 64'(fp_out_sel), 64'h1);
      chk("fp_data", fp_out_data, 64'hA1);
    end
    in_valid = 4'b0100;
    in_data[2*64 +: 64] = 64'hDEAD;
    #1;
    chk("fp_drop", 64'(fp_in_ready), 64'b0100);
    tick();
    chk("fp_sel2", 64'(fp_out_sel), 64'h2);
    chk("rr_dead_sel", 64'(rr_out_sel), 64'h2);
    chk("rr_ptr3", 64'(u_rr.ptr_q), 64'h3);
    in_valid = 4'b1111;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", 64'(rr_in_ready), 64'h0);
      tick();
      chk("bp_data", rr_out_data, 64'hDEAD);
      chk("bp_sel", 64'(rr_out_sel), 64'h2);
      chk("bp_valid", 64'(rr_out_valid), 64'h1);
      chk("bp_ptr", 64'(u_rr.ptr_q), 64'h3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", 64'(rr_in_ready), 64'b1000);
    tick();
    chk("bp_sel3", 64'(rr_out_sel), 64'h3);
    chk("bp_ptr0", 64'(u_rr.ptr_q), 64'h0);
    in_valid = 4'b0100;
    tick();
    chk("sp_ptr3", 64'(u_rr.ptr_q), 64'h3);
    in_valid = 4'b0001;
    #1;
    chk("sp_grant0", 64'(rr_in_ready), 64'b0001);
    tick();
    chk("sp_sel0", 64'(rr_out_sel), 64'h0);
    chk("sp_ptr1", 64'(u_rr.ptr_q), 64'h1);
    in_valid = 4'b0000;
    tick();
    chk("sp_empty", 64'(rr_out_valid), 64'h0);
    chk("sp_hold_sel", 64'(rr_out_sel), 64'h0);
    chk("sp_hold_data", rr_out_data, 64'hA0);
    in_valid = 4'b1111;
    tick();
    chk("mid_sel", 64'(rr_out_sel), 64'h1);
    out_ready = 1'b0;
    tick();
    chk("mid_valid", 64'(rr_out_valid), 64'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(rr_in_ready), 64'h0);
    tick();
    chk("mid_rst_valid", 64'(rr_out_valid), 64'h0);
    chk("mid_rst_ptr", 64'(u_rr.ptr_q), 64'h0);
    chk("mid_rst_data", rr_out_data, 64'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_grant", 64'(rr_in_ready), 64'b0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
